// File: rtl/jump_offset_encoder.sv
// jump_offset_encoder
//   Turns (pc, absolute target) into a PC-relative signed word offset. It
//   range-checks the offset against an OFFSET_W-bit field, packs it under a
//   6-bit opcode, and writes the resulting jump word into instruction memory
//   through a write port that waits for an acknowledge.
//
//   Optional feature: define JUMP_OFFSET_ENC_ERRCNT_EN to add err_count, a
//   saturating 8-bit count of rejected requests that only rst_n clears.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; a request is accepted only in IDLE
//   req_pc, req_target    byte addresses of the jump and of its destination
//   req_opcode            opcode placed in bits [31:26]
//   req_waddr             instruction-memory word address to write
//   imem_we/waddr/wdata   write port; held stable until imem_ack
//   imem_ack              memory accepted the write this cycle
//   done                  one-cycle completion pulse
//   err, err_code         err qualifies done; 00 ok, 01 misaligned, 10 range
//   err_count             (optional) saturating count of rejected requests
module jump_offset_encoder #(
   parameter int OFFSET_W = 26,   // opcode (6) + field must fill 32 bits
   parameter int IMEM_AW  = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [31:0]        req_pc,
   input  logic [31:0]        req_target,
   input  logic [5:0]         req_opcode,
   input  logic [IMEM_AW-1:0] req_waddr,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_waddr,
   output logic [31:0]        imem_wdata,
   input  logic               imem_ack,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code
`ifdef JUMP_OFFSET_ENC_ERRCNT_EN
   ,
   output logic [7:0]         err_count
`endif
);

   typedef enum logic [2:0] {IDLE, CALC, CHECK, WRITE, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_q, tgt_q, diff_q;
   logic [5:0]  op_q;
   logic [29:0] offset;
   logic [29-OFFSET_W+1:0] upper;
   logic        in_range;
   logic [1:0]  chk_code;

   // Word offset is the arithmetic shift of the byte difference. It fits the
   // field when every bit above the field's sign bit equals that sign bit.
   assign offset   = diff_q[31:2];
   assign upper    = offset[29:OFFSET_W-1];
   assign in_range = (&upper) | ~(|upper);

   // Misalignment is tested first, so it wins when both errors apply.
   always_comb begin
      chk_code = 2'b00;
      if (diff_q[1:0] != 2'b00) chk_code = 2'b01;
      else if (!in_range)       chk_code = 2'b10;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = CALC;
         CALC:    state_nxt = CHECK;
         CHECK:   state_nxt = (chk_code != 2'b00) ? DONE : WRITE;
         WRITE:   if (imem_ack) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state. imem_we follows the asynchronously reset
   // state, so it drops as soon as rst_n falls.
   always_comb begin
      req_ready = (state == IDLE);
      imem_we   = (state == WRITE);
      done      = (state == DONE);
   end

   // err is decoded from the latched code, so it holds after done until the
   // next accept clears err_code.
   assign err = (err_code != 2'b00);

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= '0;
         tgt_q      <= '0;
         op_q       <= '0;
         diff_q     <= '0;
         imem_waddr <= '0;
         imem_wdata <= '0;
         err_code   <= 2'b00;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               pc_q       <= req_pc;
               tgt_q      <= req_target;
               op_q       <= req_opcode;
               imem_waddr <= req_waddr;
               err_code   <= 2'b00;
            end
            // Modulo-2^32: pc + 4 wrapping past the top is legal.
            CALC:  diff_q <= tgt_q - (pc_q + 32'd4);
            CHECK: begin
               err_code <= chk_code;
               if (chk_code == 2'b00)
                  imem_wdata <= {op_q, offset[OFFSET_W-1:0]};
            end
            default: ;
         endcase
      end
   end

`ifdef JUMP_OFFSET_ENC_ERRCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_count <= 8'd0;
      else if (state == DONE && err && err_count != 8'hFF)
         err_count <= err_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_jump_offset_encoder.sv
module tb_jump_offset_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_pc, req_target;
   logic [5:0]  req_opcode;
   logic [9:0]  req_waddr;
   logic        imem_we;
   logic [9:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic        imem_ack;
   logic        done, err;
   logic [1:0]  err_code;
`ifdef JUMP_OFFSET_ENC_ERRCNT_EN
   logic [7:0]  err_count;
`endif

   int total = 0;
   int bad   = 0;
   int exp_errs = 0;

   // observations from the last run_req
   int          o_lat, o_we, o_done;
   logic [31:0] o_wdata;
   logic [9:0]  o_waddr;
   logic        o_err, o_err_hold, o_rdy, o_rdy1;
   logic [1:0]  o_code;
   bit          o_unstable;

   always #5 clk = ~clk;

   jump_offset_encoder #(.OFFSET_W(26), .IMEM_AW(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_pc(req_pc), .req_target(req_target),
      .req_opcode(req_opcode), .req_waddr(req_waddr),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .imem_ack(imem_ack), .done(done), .err(err), .err_code(err_code)
`ifdef JUMP_OFFSET_ENC_ERRCNT_EN
      , .err_count(err_count)
`endif
   );

   // Reference: signed byte distance, must be a multiple of 4, and the word
   // count must lie in [-2^25, 2^25-1]. Returns {code, word}.
   function automatic logic [33:0] model(input logic [31:0] pc, tgt, input logic [5:0] op);
      int sd, w;
      sd = int'(tgt - pc - 32'd4);
      if (sd % 4 != 0) return {2'b01, 32'h0};
      w = sd / 4;
      if (w < -33554432 || w > 33554431) return {2'b10, 32'h0};
      return {2'b00, (32'(op) << 26) | (32'(w) & 32'h03FF_FFFF)};
   endfunction

   // Drives one request and records what the DUT did; no judgement here.
   task automatic run_req(input logic [31:0] pc, tgt, input logic [5:0] op,
                          input logic [9:0] wa, input int stall, input bit spur);
      o_lat = 0; o_we = 0; o_done = 0; o_unstable = 0;
      o_wdata = 'x; o_waddr = 'x; o_err = 'x; o_code = 'x; o_err_hold = 'x;
      @(negedge clk);
      o_rdy = req_ready;
      req_valid = 1'b1; req_pc = pc; req_target = tgt; req_opcode = op; req_waddr = wa;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) o_rdy1 = req_ready;
         if (imem_we) begin
            if (o_we == 0) begin o_wdata = imem_wdata; o_waddr = imem_waddr; end
            else if (imem_wdata !== o_wdata || imem_waddr !== o_waddr) o_unstable = 1;
            o_we++;
            imem_ack = (o_we > stall);
            if (spur) begin
               req_valid = !imem_ack;
               req_pc = $urandom; req_target = $urandom; req_waddr = 10'($urandom);
            end
         end else begin
            imem_ack = 1'b0; req_valid = 1'b0;
         end
         if (done) begin
            o_done++;
            if (o_lat == 0) begin o_lat = k; o_err = err; o_code = err_code; end
         end
         if (o_lat != 0 && k >= o_lat + 2) begin o_err_hold = err; break; end
      end
      imem_ack = 1'b0; req_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req_valid = 0; imem_ack = 0;
      req_pc = 0; req_target = 0; req_opcode = 0; req_waddr = 0;
      repeat (3) @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
      total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", imem_we); end
      total++; if (imem_waddr !== 10'd0 || imem_wdata !== 32'd0) begin bad++; $display("FAIL reset_wport got=%h/%h want=0/0", imem_waddr, imem_wdata); end
      total++; if ({done, err, err_code} !== 4'b0000) begin bad++; $display("FAIL reset_status got=%b want=0000", {done, err, err_code}); end
`ifdef JUMP_OFFSET_ENC_ERRCNT_EN
      total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_errcnt got=%0d want=0", err_count); end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_forward;
      run_req(32'h100, 32'h200, 6'h02, 10'd5, 0, 0);
      total++; if (o_rdy !== 1'b1 || o_rdy1 !== 1'b0) begin bad++; $display("FAIL fwd_ready got=%b%b want=10", o_rdy, o_rdy1); end
      total++; if (o_lat !== 4) begin bad++; $display("FAIL fwd_latency got=%0d want=4", o_lat); end
      total++; if (o_wdata !== 32'h0800003F) begin bad++; $display("FAIL fwd_wdata got=%h want=0800003f", o_wdata); end
      total++; if (o_waddr !== 10'd5) begin bad++; $display("FAIL fwd_waddr got=%0d want=5", o_waddr); end
      total++; if (o_we !== 1 || o_done !== 1) begin bad++; $display("FAIL fwd_counts we=%0d done=%0d want=1/1", o_we, o_done); end
      total++; if (o_err !== 1'b0 || o_code !== 2'b00) begin bad++; $display("FAIL fwd_err got=%b/%b want=0/00", o_err, o_code); end
   endtask

   task automatic test_backward;
      logic [31:0] sx;
      run_req(32'h1000, 32'h0F00, 6'h03, 10'd7, 0, 0);
      sx = {{6{o_wdata[25]}}, o_wdata[25:0]} << 2;
      total++; if (o_wdata[25:0] !== 26'h3FFFFBF) begin bad++; $display("FAIL bwd_field got=%h want=3ffffbf", o_wdata[25:0]); end
      total++; if (sx !== 32'hFFFFFEFC) begin bad++; $display("FAIL bwd_sext got=%h want=fffffefc", sx); end
      total++; if (sx + 32'h1004 !== 32'h0F00) begin bad++; $display("FAIL bwd_roundtrip got=%h want=00000f00", sx + 32'h1004); end
      total++; if (o_wdata[31:26] !== 6'h03 || o_lat !== 4) begin bad++; $display("FAIL bwd_op_lat got=%h/%0d want=03/4", o_wdata[31:26], o_lat); end
   endtask

   task automatic test_misaligned;
      run_req(32'h100, 32'h202, 6'h02, 10'd9, 0, 0);
      exp_errs++;
      total++; if (o_lat !== 3) begin bad++; $display("FAIL mis_latency got=%0d want=3", o_lat); end
      total++; if (o_we !== 0) begin bad++; $display("FAIL mis_nowrite got=%0d want=0", o_we); end
      total++; if (o_err !== 1'b1 || o_code !== 2'b01) begin bad++; $display("FAIL mis_code got=%b/%b want=1/01", o_err, o_code); end
      total++; if (o_err_hold !== 1'b1) begin bad++; $display("FAIL mis_err_hold got=%b want=1", o_err_hold); end
`ifdef JUMP_OFFSET_ENC_ERRCNT_EN
      total++; if (err_count !== 8'd1) begin bad++; $display("FAIL mis_errcnt got=%0d want=1", err_count); end
`endif
   endtask

   task automatic test_range;
      logic [31:0] pc;
      pc = 32'h0040_0000;
      run_req(pc, pc + 32'd4 + 32'h07FF_FFFC, 6'h02, 10'd1, 0, 0);
      total++; if (o_wdata[25:0] !== 26'h1FFFFFF || o_err !== 1'b0) begin bad++; $display("FAIL rng_max got=%h/%b want=1ffffff/0", o_wdata[25:0], o_err); end
      run_req(pc, pc + 32'd4 + 32'h0800_0000, 6'h02, 10'd2, 0, 0);
      exp_errs++;
      total++; if (o_code !== 2'b10 || o_err !== 1'b1 || o_we !== 0 || o_lat !== 3) begin bad++; $display("FAIL rng_over got=%b/%b/%0d/%0d want=10/1/0/3", o_code, o_err, o_we, o_lat); end
      run_req(pc, pc + 32'd4 - 32'h0800_0000, 6'h02, 10'd3, 0, 0);
      total++; if (o_wdata[25:0] !== 26'h2000000 || o_err !== 1'b0) begin bad++; $display("FAIL rng_min got=%h/%b want=2000000/0", o_wdata[25:0], o_err); end
      run_req(pc, pc + 32'd4 + 32'h0800_0002, 6'h02, 10'd4, 0, 0);
      exp_errs++;
      total++; if (o_code !== 2'b01) begin bad++; $display("FAIL rng_both got=%b want=01", o_code); end
      run_req(32'hFFFF_FFFC, 32'h0000_0010, 6'h11, 10'd6, 0, 0);
      total++; if (o_wdata !== 32'h44000004 || o_err !== 1'b0) begin bad++; $display("FAIL rng_wrap got=%h/%b want=44000004/0", o_wdata, o_err); end
   endtask

   task automatic test_backpressure;
      logic [33:0] m;
      m = model(32'h2000, 32'h1234, 6'h2A);
      run_req(32'h2000, 32'h1234, 6'h2A, 10'h155, 3, 1);
      total++; if (o_we !== 4) begin bad++; $display("FAIL bp_we_cycles got=%0d want=4", o_we); end
      total++; if (o_unstable) begin bad++; $display("FAIL bp_stable got=changed want=stable"); end
      total++; if (o_done !== 1 || o_lat !== 7) begin bad++; $display("FAIL bp_done got=%0d/%0d want=1/7", o_done, o_lat); end
      total++; if (o_wdata !== m[31:0] || o_waddr !== 10'h155) begin bad++; $display("FAIL bp_word got=%h@%h want=%h@155", o_wdata, o_waddr, m[31:0]); end
   endtask

   task automatic test_random;
      logic [31:0] pc, tgt;
      logic [5:0]  op;
      logic [9:0]  wa;
      logic [33:0] m;
      int stall;
      for (int i = 0; i < 30; i++) begin
         pc = $urandom & 32'hFFFF_FFFC; op = 6'($urandom); wa = 10'($urandom);
         stall = $urandom_range(0, 2);
         case ($urandom_range(0, 3))
            0: tgt = pc + 32'd4 + (32'($signed(16'($urandom))) << 2);
            1: tgt = $urandom;
            2: tgt = pc + 32'd4 + ($urandom_range(0, 1) ? 32'h07FF_FFFC : 32'hF800_0000)
                     + ($urandom_range(0, 1) ? 32'd4 : 32'hFFFF_FFFC);
            default: tgt = pc + 32'd4 + ($urandom & 32'h00FF_FFFF);
         endcase
         m = model(pc, tgt, op);
         run_req(pc, tgt, op, wa, stall, 0);
         if (m[33:32] != 2'b00) exp_errs++;
         total++; if (o_code !== m[33:32] || o_err !== (m[33:32] != 2'b00)) begin bad++; $display("FAIL rnd_code i=%0d got=%b/%b want=%b", i, o_code, o_err, m[33:32]); end
         total++; if (o_lat !== ((m[33:32] != 2'b00) ? 3 : 4 + stall)) begin bad++; $display("FAIL rnd_latency i=%0d got=%0d stall=%0d", i, o_lat, stall); end
         total++; if (o_we !== ((m[33:32] != 2'b00) ? 0 : stall + 1)) begin bad++; $display("FAIL rnd_we i=%0d got=%0d stall=%0d", i, o_we, stall); end
         if (m[33:32] == 2'b00) begin
            total++; if (o_wdata !== m[31:0] || o_waddr !== wa) begin bad++; $display("FAIL rnd_word i=%0d got=%h@%h want=%h@%h", i, o_wdata, o_waddr, m[31:0], wa); end
         end
      end
`ifdef JUMP_OFFSET_ENC_ERRCNT_EN
      total++; if (err_count !== 8'((exp_errs > 255) ? 255 : exp_errs)) begin bad++; $display("FAIL rnd_errcnt got=%0d want=%0d", err_count, exp_errs); end
`endif
   endtask

   task automatic test_reset_mid_write;
      bit seen, dn;
      logic [33:0] m;
      seen = 0; dn = 0;
      @(negedge clk);
      imem_ack = 1'b0;
      req_valid = 1'b1; req_pc = 32'h200; req_target = 32'h100; req_opcode = 6'h05; req_waddr = 10'h3;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin @(negedge clk); if (imem_we) seen = 1; end
      total++; if (!seen) begin bad++; $display("FAIL rmw_enter got=no_write want=write"); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL rmw_we_drop got=%b want=0", imem_we); end
      repeat (3) begin @(negedge clk); if (done) dn = 1; end
      total++; if (dn) begin bad++; $display("FAIL rmw_no_done got=pulse want=none"); end
      rst_n = 1'b1;
      exp_errs = 0;
      @(negedge clk);
      total++; if (req_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL rmw_idle got=%b/%b want=1/0", req_ready, done); end
      m = model(32'h300, 32'h400, 6'h07);
      run_req(32'h300, 32'h400, 6'h07, 10'h22, 0, 0);
      total++; if (o_lat !== 4 || o_wdata !== m[31:0] || o_err !== 1'b0) begin bad++; $display("FAIL rmw_recover got=%0d/%h/%b want=4/%h/0", o_lat, o_wdata, o_err, m[31:0]); end
`ifdef JUMP_OFFSET_ENC_ERRCNT_EN
      total++; if (err_count !== 8'd0) begin bad++; $display("FAIL rmw_errcnt got=%0d want=0", err_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_forward();
      test_backward();
      test_misaligned();
      test_range();
      test_backpressure();
      test_random();
      test_reset_mid_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
